// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the byte-enable data memory: access sizes,
// control FSM states, store byte-enable generation and load lane extraction.
package dmem_pkg;

  localparam logic [1:0] SZ_B       = 2'b00;
  localparam logic [1:0] SZ_H       = 2'b01;
  localparam logic [1:0] SZ_W       = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic {INIT, IDLE} state_t;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << off;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Picks the addressed lane out of a little-endian word and extends it.
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic uns, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      SZ_B:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_H:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_sp_ram.sv
// Single-port RAM, per-byte write enables, registered read (1 cycle).
// No reset and no back-pressure, so it maps onto inferred RAM or a vendor macro.
module dmem_sp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  localparam int AW        = $clog2(DEPTH),
  localparam int NB        = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [NB-1:0]         we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en)
      rdata <= mem[addr];
    for (int b = 0; b < NB; b++)
      if (we[b])
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
  end

endmodule

// File: rtl/data_memory_be.sv
// Byte-addressed data memory with sized/extended loads; response 1 cycle after accept.
// req_ready low only during the DEPTH-cycle post-reset clear; responses are never stalled.
module data_memory_be
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,  // only 32 is supported
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  init_cnt;
  logic              accept, out_of_range, misaligned, req_err;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata, wdata_rep;
  logic              ld_q, uns_q;
  logic [1:0]        size_q, off_q;

  assign req_ready = (state == IDLE);
  assign init_done = (state == IDLE);
  assign accept    = req_valid & req_ready;

  assign out_of_range = |(req_addr >> (IDX_W + 2));
  assign misaligned   = ((req_size == SZ_H) & req_addr[0]) |
                        ((req_size == SZ_W) & (req_addr[1:0] != 2'b00));
  assign req_err      = out_of_range | misaligned | (req_size == SZ_ILLEGAL);

  always_comb begin
    case (req_size)
      SZ_B:    wdata_rep = {4{req_wdata[7:0]}};
      SZ_H:    wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = req_addr[IDX_W+1:2];
    ram_wdata = wdata_rep;
    case (state)
      INIT: begin
        ram_addr  = init_cnt;
        ram_we    = 4'b1111;
        ram_wdata = '0;
        if (init_cnt == IDX_W'(DEPTH - 1))
          state_nxt = IDLE;
      end
      IDLE: begin
        ram_en = accept;
        if (accept & req_we & ~req_err)
          ram_we = byte_en(req_size, req_addr[1:0]);
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT)
        init_cnt <= init_cnt + 1'b1;
    end
  end

  // Load attributes travel alongside the synchronous read to the response cycle.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      ld_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= SZ_B;
      off_q     <= 2'b00;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_err <= req_err;
        ld_q    <= ~req_we & ~req_err;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        off_q   <= req_addr[1:0];
      end
    end
  end

  // Only changes on acceptance (ram read enable and qualifiers), so it holds between responses.
  assign rsp_rdata = ld_q ? load_ext(ram_rdata, size_q, uns_q, off_q) : '0;

  dmem_sp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_data_memory_be.sv
// Bench for data_memory_be: byte-array reference model checked every cycle,
// directed literal cases, randomized traffic and reset-during-operation cases.
module tb_data_memory_be;

  localparam int DEPTH = 64;
  localparam int NBYTE = DEPTH * 4;

  logic        clk = 1'b0;
  logic        areset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  always #5 clk = ~clk;

  data_memory_be #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .areset       (areset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .init_done    (init_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory as a little-endian byte array, cycles left in clear.
  logic [7:0]  mem_m [NBYTE];
  int          m_cnt;
  bit          exp_vld;
  logic [31:0] exp_rdata;
  bit          exp_err;

  always @(posedge clk or negedge areset) begin : model
    int          nb;
    bit          err;
    logic [31:0] v;
    if (!areset) begin
      m_cnt     = DEPTH;
      exp_vld   = 0;
      exp_rdata = '0;
      exp_err   = 0;
      for (int i = 0; i < NBYTE; i++) mem_m[i] = 8'h00;
    end else if (m_cnt != 0) begin
      m_cnt--;
      exp_vld = 0;
    end else begin
      exp_vld = req_valid;
      if (req_valid) begin
        nb  = 1 << req_size;
        err = (req_addr >= NBYTE) || (req_size == 2'b11) || (req_addr % nb != 0);
        v   = '0;
        if (!err && req_we) begin
          for (int i = 0; i < nb; i++) mem_m[req_addr + i] = req_wdata[8*i +: 8];
        end else if (!err) begin
          for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_m[req_addr + i];
          if (!req_unsigned && nb == 1) v = {{24{v[7]}}, v[7:0]};
          if (!req_unsigned && nb == 2) v = {{16{v[15]}}, v[15:0]};
        end
        exp_rdata = v;
        exp_err   = err;
      end
    end
  end

  always @(negedge clk) begin
    if (!areset) begin
      chk("rst_ready", {31'd0, req_ready}, 0);
      chk("rst_init_done", {31'd0, init_done}, 0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 0);
    end else begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, m_cnt == 0});
      chk("init_done", {31'd0, init_done}, {31'd0, m_cnt == 0});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_vld});
      if (exp_vld && rsp_valid) begin
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
      end
    end
  end

  task automatic drive(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
  endtask

  // One request, then the literal response expected one cycle later.
  task automatic lit(input string name, input bit we, input logic [1:0] sz, input bit uns,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] ed, input bit ee);
    @(negedge clk);
    drive(we, sz, uns, a, wd);
    @(negedge clk);
    req_valid = 1'b0;
    chk({name, "_vld"}, {31'd0, rsp_valid}, 1);
    chk({name, "_data"}, rsp_rdata, ed);
    chk({name, "_err"}, {31'd0, rsp_err}, {31'd0, ee});
  endtask

  task automatic wait_init(input string name);
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!req_ready && cnt < 200);
    chk({name, "_cycles"}, cnt, DEPTH);
    chk({name, "_done"}, {31'd0, init_done}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    #2 areset = 1'b1;
    wait_init("init0");

    lit("lw_3c", 0, 2'b10, 0, 32'h3C, 0, 32'h0000_0000, 0);

    lit("sw_10", 1, 2'b10, 0, 32'h10, 32'h80FF_7F01, 32'h0, 0);
    lit("lb_10", 0, 2'b00, 0, 32'h10, 0, 32'h0000_0001, 0);
    lit("lb_13", 0, 2'b00, 0, 32'h13, 0, 32'hFFFF_FF80, 0);
    lit("lbu_13", 0, 2'b00, 1, 32'h13, 0, 32'h0000_0080, 0);
    lit("lh_12", 0, 2'b01, 0, 32'h12, 0, 32'hFFFF_80FF, 0);
    lit("lhu_12", 0, 2'b01, 1, 32'h12, 0, 32'h0000_80FF, 0);

    lit("sw_20", 1, 2'b10, 0, 32'h20, 32'hAAAA_AAAA, 32'h0, 0);
    lit("sb_21", 1, 2'b00, 0, 32'h21, 32'h0000_0055, 32'h0, 0);
    lit("sh_22", 1, 2'b01, 0, 32'h22, 32'h0000_1234, 32'h0, 0);
    lit("lw_20", 0, 2'b10, 0, 32'h20, 0, 32'h1234_55AA, 0);

    // Store immediately followed by a load of the same word.
    @(negedge clk);
    drive(1, 2'b10, 0, 32'h04, 32'hDEAD_BEEF);
    @(negedge clk);
    drive(0, 2'b10, 0, 32'h04, 0);
    chk("b2b_st_vld", {31'd0, rsp_valid}, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_ld_vld", {31'd0, rsp_valid}, 1);
    chk("b2b_ld_data", rsp_rdata, 32'hDEAD_BEEF);

    lit("sh_05_err", 1, 2'b01, 0, 32'h05, 32'h0000_1111, 32'h0, 1);
    lit("lw_04_keep", 0, 2'b10, 0, 32'h04, 0, 32'hDEAD_BEEF, 0);
    lit("lw_06_err", 0, 2'b10, 0, 32'h06, 0, 32'h0, 1);
    lit("sz11_08_err", 1, 2'b11, 0, 32'h08, 32'hFFFF_FFFF, 32'h0, 1);
    lit("lw_08_keep", 0, 2'b10, 0, 32'h08, 0, 32'h0, 0);
    lit("lw_100_err", 0, 2'b10, 0, 32'h100, 0, 32'h0, 1);
    lit("sw_100_err", 1, 2'b10, 0, 32'h100, 32'h5555_5555, 32'h0, 1);
    lit("lw_00_keep", 0, 2'b10, 0, 32'h00, 0, 32'h0, 0);

    for (int i = 0; i < 800; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      @(negedge clk);
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       a = (32'h100 << $urandom_range(0, 20)) | 32'($urandom_range(0, 255));
        1, 2:    a = 32'($urandom_range(0, NBYTE - 1));
        default: a = 32'($urandom_range(0, 63));
      endcase
      drive($urandom_range(0, 1), sz, $urandom_range(0, 1), a, $urandom);
      req_valid = ($urandom_range(0, 9) < 7);
    end
    @(negedge clk);
    req_valid = 1'b0;

    // Reset in the middle of the clear sequence.
    @(negedge clk);
    #2 areset = 1'b0;
    @(negedge clk);
    #2 areset = 1'b1;
    repeat (30) @(negedge clk);
    #2 areset = 1'b0;
    @(negedge clk);
    #2 areset = 1'b1;
    wait_init("init_mid");

    // Reset right after a load is accepted drops its response.
    lit("sw_30", 1, 2'b10, 0, 32'h30, 32'hCAFE_F00D, 32'h0, 0);
    @(negedge clk);
    drive(0, 2'b10, 0, 32'h30, 0);
    @(posedge clk);
    #1 areset = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("drop_rsp_valid", {31'd0, rsp_valid}, 0);
    #2 areset = 1'b1;
    wait_init("init_after_load");
    lit("lw_30_cleared", 0, 2'b10, 0, 32'h30, 0, 32'h0, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_memory_be.md
Name: data_memory_be

Overview:
- Parametrised successor to the single-cycle data memory.
- Byte-addressed, single-port RAM with byte/half/word loads and stores, and sign/zero extension on loads.
- Valid/ready request handshake with a registered 1-cycle read response; misaligned and out-of-range accesses are flagged.
- Post-reset hardware clear, one word per cycle, so the array maps to inferred RAM. Sits between the core's load/store path and the memory array.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be 32. 64 is reserved; only 32 is supported.
- DEPTH, 64, number of words; power of two, minimum 4.
- ADDR_WIDTH, 32, request byte-address width.

Ports:
- clk  in  1  clock, rising edge.
- areset  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- rsp_valid  out  1  response pulse, one cycle after acceptance, for both loads and stores.
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- rsp_err  out  1  accompanies rsp_valid: misaligned, out of range, or illegal size.
- init_done  out  1  high once the clear sequence completes.

Behaviour:
- Reset (areset low, asynchronous):
  - FSM goes to INIT; init counter = 0.
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, init_done = 0.
  - Any pending response is dropped. Array contents are not reset asynchronously.
- INIT state:
  - Writes 0 to word[init_cnt] each cycle; init_cnt increments.
  - After word DEPTH-1: go to IDLE, init_done = 1. INIT lasts exactly DEPTH cycles after reset release.
  - req_ready = 0 throughout.
- IDLE state:
  - req_ready = 1. Acceptance = req_valid & req_ready.
  - No back-pressure on responses; rsp_valid pulses exactly 1 cycle after each acceptance.
  - Back-to-back requests accepted every cycle.
- Address decode:
  - word index = req_addr[log2(DEPTH)+1:2]; byte offset = req_addr[1:0].
  - Out of range: any req_addr bit at or above log2(DEPTH)+2 is set.
  - Misaligned: half with offset[0] = 1, or word with offset != 0.
  - Error = out of range | misaligned | size == 11.
- Store, accepted with no error:
  - Byte enables: byte = 1 << off; half = 0011 << off; word = 1111.
  - Write data is replicated into lanes (byte to all 4 lanes, half to both halves); only enabled bytes are written at the clock edge.
  - Next cycle: rsp_valid = 1, rsp_err = 0, rsp_rdata = 0.
- Store with error: memory is unmodified; next cycle rsp_valid = 1, rsp_err = 1.
- Load:
  - Word is read synchronously at acceptance; size, unsigned and offset are registered.
  - Next cycle: selected lane is extracted and sign- or zero-extended onto rsp_rdata.
  - Load with error: rsp_rdata = 0, rsp_err = 1.
- Ordering: a store in cycle N followed by a load to the same word in cycle N+1 returns the stored data. Single port, so no same-cycle conflict is possible.
- rsp_rdata and rsp_err hold their last values while rsp_valid = 0; the bench checks them only when rsp_valid = 1.
- Reset asserted mid-INIT: clear restarts from word 0.

Decomposition:
- Shared package dmem_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_ILLEGAL;
  - FSM state enum {INIT, IDLE};
  - function for byte-enable generation;
  - function for load extension.
- One natural sub-module: dmem_sp_ram, a plain single-port RAM with per-byte write enables and a registered read, so a vendor macro can be swapped in. Control, FSM, alignment checks and extension stay in the top.

Test Plan:
- Release reset -> req_ready = 0 for exactly 64 cycles, then init_done = 1; LW at 0x3C -> rsp_rdata = 0x00000000, rsp_err = 0.
- SW 0x80FF7F01 at 0x10; LB 0x10 -> 0x00000001; LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x12 -> 0xFFFF80FF; LHU 0x12 -> 0x000080FF.
- SW 0xAAAAAAAA at 0x20, then SB 0x55 at 0x21 and SH 0x1234 at 0x22 -> LW 0x20 returns 0x123455AA.
- SH at 0x05, LW at 0x06, req_size = 11 at 0x08, LW at 0x100 -> each gives rsp_err = 1 with rsp_rdata = 0, and the targeted words remain unchanged.
- Back-to-back SW 0xDEADBEEF at 0x04 then LW 0x04 next cycle -> rsp_valid in two consecutive cycles, second has rsp_rdata = 0xDEADBEEF.
- Assert areset during cycle 30 of INIT, and again one cycle after an accepted load -> no rsp_valid emitted, INIT restarts, full 64-cycle clear observed.
